// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg_disp_pkg;

  localparam int unsigned DATA_W           = 32;
  localparam int unsigned DEF_DWELL_CYCLES = 50_000_000;
  localparam int unsigned DEF_PAGE_CYCLES  = 100_000_000;

  typedef enum logic [1:0] {IDLE, SHOW, HOLD} seg_state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Requester-to-arbiter-to-driver bus: requests in, display controls out.
interface seg_display_arbiter_if
  import seg_disp_pkg::*;
#(
  parameter int unsigned NREQ = 3
);
  logic [NREQ-1:0]        req;
  logic [DATA_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]        req_wide;
  logic [NREQ-1:0]        grant;
  logic [DATA_W-1:0]      displayed_number;
  logic                   display_sel;
  logic                   page_sel;
  logic                   busy;

  modport master (
    output req, req_data, req_wide,
    input  grant, displayed_number, display_sel, page_sel, busy
  );

  modport slave (
    input  req, req_data, req_wide,
    output grant, displayed_number, display_sel, page_sel, busy
  );
endinterface

// File: rtl/seg_display_arbiter_prio_pick.sv
// Combinational one-hot picker; the request at index i_base has highest priority,
// then i_base+1, ... wrapping modulo NREQ.
module seg_prio_pick
  import seg_disp_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [cnt_w(NREQ)-1:0]  i_base,
  output logic                    o_valid,
  output logic [cnt_w(NREQ)-1:0]  o_idx,
  output logic [NREQ-1:0]         o_onehot
);
  localparam int unsigned IW = cnt_w(NREQ);

  logic [2*NREQ-1:0] w_rot;
  int                w_sum;

  always_comb begin
    w_rot   = {i_req, i_req} >> i_base;
    w_sum   = 0;
    o_valid = 1'b0;
    o_idx   = '0;
    // Descending scan so the smallest offset from the base wins.
    for (int off = int'(NREQ) - 1; off >= 0; off--) begin
      if (w_rot[off]) begin
        w_sum = int'(i_base) + off;
        if (w_sum >= int'(NREQ)) w_sum = w_sum - int'(NREQ);
        o_valid = 1'b1;
        o_idx   = IW'(w_sum);
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      o_onehot[i] = o_valid && (o_idx == IW'(i));
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Display arbiter with dwell protection and half paging for wide values.
// Optional SEG_ARB_ROUND_ROBIN_EN: rotating priority instead of fixed index-0-first.
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter int unsigned NREQ         = 3,
  parameter int unsigned DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int unsigned PAGE_CYCLES  = DEF_PAGE_CYCLES
) (
  input logic                  i_clk,
  input logic                  i_reset,
  seg_display_arbiter_if.slave bus
);
  localparam int unsigned IW = cnt_w(NREQ);
  localparam int unsigned DW = cnt_w(DWELL_CYCLES);
  localparam int unsigned PW = cnt_w(PAGE_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [PW-1:0] PAGE_LAST  = PW'(PAGE_CYCLES - 1);

  seg_state_e        r_state, w_state_nxt;
  logic [NREQ-1:0]   r_grant, w_grant_nxt;
  logic [IW-1:0]     r_owner, w_owner_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_disp_sel, w_disp_sel_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_page_sel, w_page_sel_nxt;
  logic [DW-1:0]     r_dwell_cnt, w_dwell_nxt;
  logic [PW-1:0]     r_page_cnt, w_page_nxt;

  logic [IW-1:0]     w_base;
  logic              w_pick_valid;
  logic [IW-1:0]     w_pick_idx;
  logic [NREQ-1:0]   w_pick_onehot;
  logic [DATA_W-1:0] w_pick_data, w_owner_data;
  logic              w_owner_req, w_owner_wide;
  logic              w_dwell_done, w_do_grant, w_go_idle;

  seg_prio_pick #(.NREQ(NREQ)) u_pick (
    .i_req    (bus.req),
    .i_base   (w_base),
    .o_valid  (w_pick_valid),
    .o_idx    (w_pick_idx),
    .o_onehot (w_pick_onehot)
  );

`ifdef SEG_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] r_base;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_base <= '0;
    end else if (w_do_grant) begin
      r_base <= (w_pick_idx == IW'(NREQ - 1)) ? '0 : w_pick_idx + IW'(1);
    end
  end
  assign w_base = r_base;
`else
  assign w_base = '0;
`endif

  always_comb begin
    w_owner_data = '0;
    w_owner_req  = 1'b0;
    w_owner_wide = 1'b0;
    w_pick_data  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (r_owner == IW'(i)) begin
        w_owner_data = bus.req_data[i*DATA_W +: DATA_W];
        w_owner_req  = bus.req[i];
        w_owner_wide = bus.req_wide[i];
      end
      if (w_pick_idx == IW'(i)) w_pick_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  assign w_dwell_done = (r_dwell_cnt == DWELL_LAST);

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_owner_nxt    = r_owner;
    w_data_nxt     = r_data;
    w_disp_sel_nxt = r_disp_sel;
    w_busy_nxt     = r_busy;
    w_page_sel_nxt = 1'b0;
    w_page_nxt     = '0;
    w_dwell_nxt    = r_dwell_cnt;
    w_do_grant     = 1'b0;
    w_go_idle      = 1'b0;

    if (r_state != IDLE) begin
      if (!w_dwell_done) w_dwell_nxt = r_dwell_cnt + DW'(1);
      if (w_owner_wide) begin
        w_page_sel_nxt = (r_page_cnt == PAGE_LAST) ? ~r_page_sel : r_page_sel;
        w_page_nxt     = (r_page_cnt == PAGE_LAST) ? '0 : r_page_cnt + PW'(1);
      end
    end

    unique case (r_state)
      IDLE: w_do_grant = w_pick_valid;
      SHOW: begin
        if (!w_dwell_done) begin
          if (w_owner_req) w_data_nxt = w_owner_data;
          else             w_state_nxt = HOLD;
        end else if (!w_pick_valid) begin
          w_go_idle = 1'b1;
        end else if (w_pick_idx != r_owner) begin
          w_do_grant = 1'b1;
        end else begin
          w_data_nxt = w_owner_data;
        end
      end
      HOLD: begin
        if (w_dwell_done && !w_pick_valid) begin
          w_go_idle = 1'b1;
        end else if (w_dwell_done && (w_pick_idx != r_owner)) begin
          w_do_grant = 1'b1;
        end else if (w_owner_req) begin
          w_state_nxt = SHOW;
          w_data_nxt  = w_owner_data;
        end
      end
      default: w_go_idle = 1'b1;
    endcase

    if (w_do_grant) begin
      w_state_nxt    = SHOW;
      w_grant_nxt    = w_pick_onehot;
      w_owner_nxt    = w_pick_idx;
      w_data_nxt     = w_pick_data;
      w_disp_sel_nxt = 1'b1;
      w_busy_nxt     = 1'b1;
      w_dwell_nxt    = '0;
      w_page_nxt     = '0;
      w_page_sel_nxt = 1'b0;
    end else if (w_go_idle) begin
      // displayed_number is left as is so the driver keeps showing it.
      w_state_nxt    = IDLE;
      w_grant_nxt    = '0;
      w_disp_sel_nxt = 1'b0;
      w_busy_nxt     = 1'b0;
      w_dwell_nxt    = '0;
      w_page_nxt     = '0;
      w_page_sel_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_owner     <= '0;
      r_data      <= '0;
      r_disp_sel  <= 1'b0;
      r_busy      <= 1'b0;
      r_page_sel  <= 1'b0;
      r_dwell_cnt <= '0;
      r_page_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_owner     <= w_owner_nxt;
      r_data      <= w_data_nxt;
      r_disp_sel  <= w_disp_sel_nxt;
      r_busy      <= w_busy_nxt;
      r_page_sel  <= w_page_sel_nxt;
      r_dwell_cnt <= w_dwell_nxt;
      r_page_cnt  <= w_page_nxt;
    end
  end

  assign bus.grant            = r_grant;
  assign bus.displayed_number = r_data;
  assign bus.display_sel      = r_disp_sel;
  assign bus.page_sel         = r_page_sel;
  assign bus.busy             = r_busy;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with DWELL_CYCLES=8, PAGE_CYCLES=4.
module tb_seg_display_arbiter;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  seg_display_arbiter_if #(.NREQ(3)) bus ();

  seg_display_arbiter #(
    .NREQ         (3),
    .DWELL_CYCLES (8),
    .PAGE_CYCLES  (4)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [31:0] val);
    bus.req_data[idx*32 +: 32] = val;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"}, 32'(bus.grant), 32'h0);
    check({tag, "_num"}, bus.displayed_number, 32'h0);
    check({tag, "_dsel"}, 32'(bus.display_sel), 32'h0);
    check({tag, "_psel"}, 32'(bus.page_sel), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    logic [2:0] exp_g;
    logic [31:0] exp_d;
    logic [31:0] rr_data [3];
    n_tests = 0;
    n_fail  = 0;
    reset        = 1'b1;
    bus.req      = '0;
    bus.req_wide = '0;
    bus.req_data = '0;

    // 1. reset then idle
    tick(2);
    reset = 1'b0;
    tick(20);
    check_reset_vals("idle");

    // 2. single requester, live update, drop to IDLE
    bus.req = 3'b010;
    set_data(1, 32'h0000_1234);
    tick(1);
    check("single_grant", 32'(bus.grant), 32'h2);
    check("single_num", bus.displayed_number, 32'h1234);
    check("single_dsel", 32'(bus.display_sel), 32'h1);
    check("single_busy", 32'(bus.busy), 32'h1);
    set_data(1, 32'h0000_5678);
    tick(1);
    check("track_num", bus.displayed_number, 32'h5678);
    tick(18);
    bus.req = 3'b000;
    tick(1);
    check("drop_grant", 32'(bus.grant), 32'h0);
    check("drop_dsel", 32'(bus.display_sel), 32'h0);
    check("drop_busy", 32'(bus.busy), 32'h0);
    check("drop_num_kept", bus.displayed_number, 32'h5678);

    // 3. dwell protection against a higher-priority requester
    bus.req = 3'b100;
    set_data(2, 32'h2222_0002);
    set_data(0, 32'h0000_00A0);
    tick(1);
    check("dwell_first", 32'(bus.grant), 32'h4);
    tick(2);
    bus.req = 3'b101;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("dwell_hold", 32'(bus.grant), 32'h4);
    end
    check("dwell_num", bus.displayed_number, 32'h2222_0002);
    tick(1);
    check("dwell_switch", 32'(bus.grant), 32'h1);
    check("dwell_cap", bus.displayed_number, 32'h0000_00A0);
    bus.req = 3'b000;
    tick(10);
    check("dwell_idle", 32'(bus.busy), 32'h0);

    // 4. HOLD: owner drops before dwell_done while req[2] waits
    bus.req = 3'b010;
    set_data(1, 32'h0000_0011);
    set_data(2, 32'h0000_BEEF);
    tick(1);
    check("hold_grant", 32'(bus.grant), 32'h2);
    tick(2);
    bus.req = 3'b110;
    set_data(1, 32'h0000_0033);
    tick(1);
    check("hold_track", bus.displayed_number, 32'h33);
    bus.req = 3'b100;
    set_data(1, 32'h0000_0044);
    tick(1);
    check("hold_frozen", bus.displayed_number, 32'h33);
    check("hold_owner", 32'(bus.grant), 32'h2);
    tick(3);
    check("hold_last_g", 32'(bus.grant), 32'h2);
    check("hold_last_num", bus.displayed_number, 32'h33);
    check("hold_last_dsel", 32'(bus.display_sel), 32'h1);
    tick(1);
    check("hold_switch", 32'(bus.grant), 32'h4);
    check("hold_sw_num", bus.displayed_number, 32'h0000_BEEF);
    bus.req = 3'b000;
    tick(10);
    check("hold_idle", 32'(bus.busy), 32'h0);

    // 5. paging for a wide value, then switch to a narrow owner
    bus.req      = 3'b001;
    bus.req_wide = 3'b001;
    set_data(0, 32'hABCD_1234);
    set_data(1, 32'h0000_0777);
    tick(1);
    check("page_num", bus.displayed_number, 32'hABCD_1234);
    for (int k = 0; k < 14; k++) begin
      if (k > 0) tick(1);
      check($sformatf("page_k%0d", k), 32'(bus.page_sel), 32'((k / 4) % 2));
    end
    bus.req = 3'b010;
    tick(1);
    check("page_sw_grant", 32'(bus.grant), 32'h2);
    check("page_sw_psel", 32'(bus.page_sel), 32'h0);
    check("page_sw_num", bus.displayed_number, 32'h777);
    tick(1);
    check("page_narrow", 32'(bus.page_sel), 32'h0);

    // 6. reset mid-dwell, then all three requesters held high
    reset = 1'b1;
    tick(1);
    check_reset_vals("rst_mid");
    reset        = 1'b0;
    bus.req      = 3'b111;
    bus.req_wide = 3'b000;
    rr_data[0] = 32'h0000_00A0;
    rr_data[1] = 32'h0000_00B1;
    rr_data[2] = 32'h0000_00C2;
    for (int i = 0; i < 3; i++) set_data(i, rr_data[i]);
    tick(1);
    check("all_first", 32'(bus.grant), 32'h1);
    for (int r = 1; r <= 3; r++) begin
      tick(8);
`ifdef SEG_ARB_ROUND_ROBIN_EN
      exp_g = 3'b001 << (r % 3);
      exp_d = rr_data[r % 3];
`else
      exp_g = 3'b001;
      exp_d = rr_data[0];
`endif
      check($sformatf("all_g%0d", r), 32'(bus.grant), 32'(exp_g));
      check($sformatf("all_d%0d", r), bus.displayed_number, exp_d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
